// File: rtl/cordic_iter_sequencer.sv
// Iteration sequencer for the expanded-hyperbolic CORDIC exponential unit.
// It steps the shift/scale ROM address, pulses the ROM enable and handshakes each iteration.
module cordic_iter_sequencer #(
  parameter int D          = 5,
  parameter int START_ADRS = 0,
  parameter int END_ADRS   = 31
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         BEG_SEQ,
  input  logic         ITER_ACK,
  output logic [D-1:0] ADRS,
  output logic         EN_ROM1,
  output logic         EN_ITER,
  output logic         LAST_ITER,
  output logic         BUSY,
  output logic         READY,
  output logic [1:0]   STATE_DBG
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ITER  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [D-1:0] START_A = D'(START_ADRS);
  localparam logic [D-1:0] END_A   = D'(END_ADRS);

  state_t       state_q, state_d;
  logic [D-1:0] adrs_q, adrs_d;
  logic         at_end;

  assign at_end = (adrs_q == END_A);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      adrs_q  <= '0;
    end else begin
      state_q <= state_d;
      adrs_q  <= adrs_d;
    end
  end

  // The end check comes before the increment, so END_A = 2^D-1 never wraps.
  always_comb begin
    state_d = state_q;
    adrs_d  = adrs_q;
    unique case (state_q)
      S_IDLE: begin
        if (BEG_SEQ) begin
          state_d = S_FETCH;
          adrs_d  = START_A;
        end
      end
      S_FETCH: begin
        state_d = S_ITER;
      end
      S_ITER: begin
        if (ITER_ACK) begin
          if (at_end) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
            adrs_d  = adrs_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        // Holding BEG_SEQ high parks here so a level start cannot auto-restart.
        if (!BEG_SEQ) begin
          state_d = S_IDLE;
          adrs_d  = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        adrs_d  = '0;
      end
    endcase
  end

  // Moore decode: every output depends only on state_q and adrs_q.
  assign ADRS      = adrs_q;
  assign EN_ROM1   = (state_q == S_FETCH);
  assign EN_ITER   = (state_q == S_ITER);
  assign BUSY      = (state_q == S_FETCH) || (state_q == S_ITER);
  assign READY     = (state_q == S_DONE);
  assign LAST_ITER = BUSY && at_end;
  assign STATE_DBG = state_q;

endmodule

// File: tb/tb_cordic_iter_sequencer.sv
// Directed bench for cordic_iter_sequencer: default instance plus a START=END=31 corner instance.
module tb_cordic_iter_sequencer;

  logic       clk = 1'b0;
  logic       rst, beg, ack;
  logic       c_rst, c_beg, c_ack;
  logic [4:0] m_adrs, c_adrs;
  logic       m_rom, m_iter, m_last, m_busy, m_ready;
  logic       c_rom, c_iter, c_last, c_busy, c_ready;
  logic [1:0] m_state, c_state;
  logic [9:0] m_obs, c_obs;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  cordic_iter_sequencer #(.D(5), .START_ADRS(0), .END_ADRS(31)) u_dut (
    .CLK(clk), .RST(rst), .BEG_SEQ(beg), .ITER_ACK(ack),
    .ADRS(m_adrs), .EN_ROM1(m_rom), .EN_ITER(m_iter), .LAST_ITER(m_last),
    .BUSY(m_busy), .READY(m_ready), .STATE_DBG(m_state)
  );

  cordic_iter_sequencer #(.D(5), .START_ADRS(31), .END_ADRS(31)) u_corner (
    .CLK(clk), .RST(c_rst), .BEG_SEQ(c_beg), .ITER_ACK(c_ack),
    .ADRS(c_adrs), .EN_ROM1(c_rom), .EN_ITER(c_iter), .LAST_ITER(c_last),
    .BUSY(c_busy), .READY(c_ready), .STATE_DBG(c_state)
  );

  // Observation vector: {ADRS, EN_ROM1, EN_ITER, LAST_ITER, BUSY, READY}
  assign m_obs = {m_adrs, m_rom, m_iter, m_last, m_busy, m_ready};
  assign c_obs = {c_adrs, c_rom, c_iter, c_last, c_busy, c_ready};

  function automatic logic [9:0] mk(input int a, input logic r, input logic i,
                                    input logic l, input logic b, input logic rd);
    return {5'(a), r, i, l, b, rd};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  // One FETCH cycle then one ITER cycle at address a; ack must be high.
  task automatic pair(input int a, input string ph);
    chk($sformatf("%s_fetch_%0d", ph, a), m_obs, mk(a, 1'b1, 1'b0, a == 31, 1'b1, 1'b0));
    tick();
    chk($sformatf("%s_iter_%0d", ph, a), m_obs, mk(a, 1'b0, 1'b1, a == 31, 1'b1, 1'b0));
    tick();
  endtask

  initial begin
    rst = 1'b1; beg = 1'b0; ack = 1'b0;
    c_rst = 1'b1; c_beg = 1'b0; c_ack = 1'b0;
    tick();
    tick();
    chk("reset_main", m_obs, 10'd0);
    chk("reset_corner", c_obs, 10'd0);
    rst = 1'b0; c_rst = 1'b0;
    tick();
    chk("idle_after_reset", m_obs, 10'd0);

    // Spurious ACK in IDLE
    ack = 1'b1;
    tick();
    chk("idle_ack_ignored", m_obs, 10'd0);

    // Full sequence with ACK tied high; BEG_SEQ sampled at edge 0
    beg = 1'b1;
    tick();
    beg = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i == 5) beg = 1'b1;
      if (i == 7) beg = 1'b0;
      pair(i, "full");
    end
    chk("full_done_c65", m_obs, mk(31, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    chk("full_done_state", {8'd0, m_state}, 10'd3);
    tick();
    chk("full_back_idle", m_obs, 10'd0);

    // ACK stall at address 10; ACK held high across the FETCH->ITER edge
    beg = 1'b1;
    tick();
    beg = 1'b0;
    for (int i = 0; i < 10; i++) pair(i, "stall_pre");
    chk("stall_fetch_10", m_obs, mk(10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    tick();
    chk("stall_iter_10", m_obs, mk(10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
    ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("stall_hold_%0d", i), m_obs, mk(10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
    end
    ack = 1'b1;
    tick();
    chk("stall_release_fetch_11", m_obs, mk(11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    tick();
    chk("stall_iter_11", m_obs, mk(11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
    tick();

    // Held start: BEG_SEQ high through completion
    beg = 1'b1;
    for (int i = 12; i < 32; i++) pair(i, "held");
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("held_done_%0d", i), m_obs, mk(31, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      tick();
    end
    beg = 1'b0;
    chk("held_done_last", m_obs, mk(31, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    tick();
    chk("held_drop_idle", m_obs, 10'd0);
    ack = 1'b1;
    tick();
    chk("idle_ack_again", m_obs, 10'd0);

    // Restart, then asynchronous reset while in ITER at address 7
    beg = 1'b1;
    tick();
    beg = 1'b0;
    for (int i = 0; i < 7; i++) pair(i, "restart");
    chk("restart_fetch_7", m_obs, mk(7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    tick();
    chk("restart_iter_7", m_obs, mk(7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
    rst = 1'b1;
    #1;
    chk("rst_async_immediate", m_obs, 10'd0);
    beg = 1'b1;
    tick();
    chk("rst_held", m_obs, 10'd0);
    rst = 1'b0;
    beg = 1'b0;
    tick();
    chk("rst_release_idle_0", m_obs, 10'd0);
    tick();
    chk("rst_release_idle_1", m_obs, 10'd0);

    // Corner instance: START_ADRS == END_ADRS == 31
    c_beg = 1'b1;
    tick();
    c_beg = 1'b0;
    chk("corner_fetch", c_obs, mk(31, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0));
    tick();
    chk("corner_iter", c_obs, mk(31, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
    tick();
    chk("corner_iter_wait", c_obs, mk(31, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
    c_ack = 1'b1;
    tick();
    chk("corner_done", c_obs, mk(31, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    c_ack = 1'b0;
    tick();
    chk("corner_idle", c_obs, 10'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
